// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the write-back stage (A) and a
// buffered secondary writer (B). It also owns the registered output port.
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wbRegWrite,
  input  logic                   wbOut,
  input  logic [2:0]             wbAddr,
  input  logic [15:0]            wbData,
  output logic                   wbStall,
  input  logic                   secValid,
  output logic                   secReady,
  input  logic [2:0]             secAddr,
  input  logic [15:0]            secData,
  output logic                   rfWriteEn,
  output logic [2:0]             rfWriteAddr,
  output logic [15:0]            rfWriteData,
  output logic [15:0]            outputPort,
  output logic                   outStrobe,
  output logic [$clog2(DEPTH):0] pendingCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] live_q;
  logic [2:0]       addr_q [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [AW-1:0]    age;

  logic head_valid, head_live, a_req, force_b, grant_a, grant_b;
  logic pop, push, a_kill, head_kill;

  // B handshake: an entry transfers on a rising edge where secValid && secReady.
  // secReady depends only on current occupancy, so a full FIFO accepts nothing
  // even in a cycle that pops.
  assign secReady   = pendingCount < (PW + 1)'(DEPTH);
  assign push       = secValid && secReady;

  assign head_valid = pendingCount != '0;
  assign head_live  = head_valid && live_q[rd_ptr];
  assign a_req      = wbRegWrite || wbOut;
  assign force_b    = head_live && (age >= AW'(STARVE_LIMIT));
  assign grant_a    = a_req && !force_b;
  assign grant_b    = force_b || (head_live && !a_req);
  assign wbStall    = force_b && a_req;

  // A killed head leaves the queue silently, so pops also happen alongside A grants.
  assign pop        = head_valid && (grant_b || !head_live);
  assign a_kill     = grant_a && wbRegWrite;
  assign head_kill  = a_kill && head_live && (addr_q[rd_ptr] == wbAddr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      pendingCount <= '0;
      age          <= '0;
      rfWriteEn    <= 1'b0;
      rfWriteAddr  <= '0;
      rfWriteData  <= '0;
      outputPort   <= '0;
      outStrobe    <= 1'b0;
    end else begin
      // A's data is newer than anything already queued for the same register.
      if (a_kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_q[i] == wbAddr) live_q[i] <= 1'b0;
        end
      end
      // Enqueue comes after the kill loop so a same-cycle entry stays live.
      if (push) begin
        live_q[wr_ptr] <= 1'b1;
        addr_q[wr_ptr] <= secAddr;
        data_q[wr_ptr] <= secData;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   pendingCount <= pendingCount + 1'b1;
        2'b01:   pendingCount <= pendingCount - 1'b1;
        default: pendingCount <= pendingCount;
      endcase

      if (grant_b || !head_live || head_kill) age <= '0;
      else if (age < AW'(STARVE_LIMIT))       age <= age + 1'b1;

      rfWriteEn <= grant_b || a_kill;
      if (grant_b) begin
        rfWriteAddr <= addr_q[rd_ptr];
        rfWriteData <= data_q[rd_ptr];
      end else if (a_kill) begin
        rfWriteAddr <= wbAddr;
        rfWriteData <= wbData;
      end

      outStrobe <= grant_a && wbOut;
      if (grant_a && wbOut) outputPort <= wbData;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a vector table for single-cycle behaviour plus
// hand-written multi-cycle sequences, with register writes tracked by a scoreboard.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wbRegWrite, wbOut;
  logic [2:0]  wbAddr;
  logic [15:0] wbData;
  logic        wbStall;
  logic        secValid, secReady;
  logic [2:0]  secAddr;
  logic [15:0] secData;
  logic        rfWriteEn;
  logic [2:0]  rfWriteAddr;
  logic [15:0] rfWriteData;
  logic [15:0] outputPort;
  logic        outStrobe;
  logic [2:0]  pendingCount;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [18:0] exp_q[$];

  rf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .wbRegWrite(wbRegWrite), .wbOut(wbOut), .wbAddr(wbAddr), .wbData(wbData),
    .wbStall(wbStall),
    .secValid(secValid), .secReady(secReady), .secAddr(secAddr), .secData(secData),
    .rfWriteEn(rfWriteEn), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
    .outputPort(outputPort), .outStrobe(outStrobe), .pendingCount(pendingCount)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rw, input logic out, input logic [2:0] a,
                       input logic [15:0] d, input logic sv, input logic [2:0] sa,
                       input logic [15:0] sd);
    wbRegWrite = rw;
    wbOut      = out;
    wbAddr     = a;
    wbData     = d;
    secValid   = sv;
    secAddr    = sa;
    secData    = sd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst && rfWriteEn) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                 rfWriteAddr, rfWriteData);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("rf_write", {13'd0, rfWriteAddr, rfWriteData}, {13'd0, e});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rw, out;
    logic [2:0]  a;
    logic [15:0] d;
    logic        sv;
    logic [2:0]  sa;
    logic [15:0] sd;
    logic        stall, ready, we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        strobe;
    logic [15:0] port;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic apply_row(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    drive(v.rw, v.out, v.a, v.d, v.sv, v.sa, v.sd);
    #1;
    check({tag, "_stall"}, wbStall, v.stall);
    check({tag, "_ready"}, secReady, v.ready);
    if (v.we) exp_q.push_back({v.wa, v.wd});
    tick();
    check({tag, "_we"}, rfWriteEn, v.we);
    check({tag, "_waddr"}, rfWriteAddr, v.wa);
    check({tag, "_wdata"}, rfWriteData, v.wd);
    check({tag, "_strobe"}, outStrobe, v.strobe);
    check({tag, "_port"}, outputPort, v.port);
    check({tag, "_count"}, pendingCount, v.cnt);
  endtask

  initial begin
    int k;
    int nb;
    bit exp_ready;
    logic [2:0] cnt_exp [12];

    //             rw   out  a     d         sv   sa    sd         stall ready we   wa    wd        strb port      cnt
    vecs[0] = '{1'b1, 1'b0, 3'd1, 16'h1111, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 16'h0000, 3'd0};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 16'h00FF, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd1, 16'h1111, 1'b1, 16'h00FF, 3'd0};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd1, 16'h1111, 1'b0, 16'h00FF, 3'd0};
    vecs[3] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd1, 16'h1111, 1'b0, 16'h00FF, 3'd1};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h00FF, 3'd0};
    vecs[5] = '{1'b1, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd4, 16'h4444, 1'b1, 16'h4444, 3'd0};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd4, 16'h4444, 1'b0, 16'h4444, 3'd0};

    // reset state
    rst = 1'b0;
    idle();
    #12;
    check("reset_we", rfWriteEn, 0);
    check("reset_waddr", rfWriteAddr, 0);
    check("reset_wdata", rfWriteData, 0);
    check("reset_port", outputPort, 0);
    check("reset_strobe", outStrobe, 0);
    check("reset_count", pendingCount, 0);
    check("reset_ready", secReady, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) apply_row(vecs[i], i);

    // starvation: A writes every cycle, B's single entry is forced after 8 waits
    k = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b0, 3'd1, 16'(16'h1000 + k), i == 0, 3'd6, 16'h6666);
      #1;
      check($sformatf("starve_stall_c%0d", i), wbStall, (i == 9));
      if (i == 0) check("starve_ready", secReady, 1);
      if (i == 9) exp_q.push_back({3'd6, 16'h6666});
      else begin
        exp_q.push_back({3'd1, 16'(16'h1000 + k)});
        k++;
      end
      tick();
      check($sformatf("starve_count_c%0d", i), pendingCount, (i < 9) ? 1 : 0);
    end
    idle();
    tick();
    tick();

    // kill: queued B to r5 is superseded by A's newer write to r5
    drive(1'b1, 1'b0, 3'd2, 16'h2222, 1'b1, 3'd5, 16'hAAAA);
    exp_q.push_back({3'd2, 16'h2222});
    tick();
    check("kill_count_queued", pendingCount, 1);
    drive(1'b1, 1'b0, 3'd5, 16'hBBBB, 1'b0, 3'd0, 16'h0);
    #1;
    check("kill_stall", wbStall, 0);
    exp_q.push_back({3'd5, 16'hBBBB});
    tick();
    check("kill_count_dead", pendingCount, 1);
    check("kill_wdata", rfWriteData, 16'hBBBB);
    idle();
    tick();
    check("kill_pop_count", pendingCount, 0);
    check("kill_pop_no_write", rfWriteEn, 0);
    tick();
    check("kill_no_late_write", rfWriteEn, 0);

    // same cycle: A writes r2 while B enqueues r2; the B entry stays live
    drive(1'b1, 1'b0, 3'd2, 16'h2A2A, 1'b1, 3'd2, 16'h2B2B);
    exp_q.push_back({3'd2, 16'h2A2A});
    tick();
    check("same_count", pendingCount, 1);
    idle();
    exp_q.push_back({3'd2, 16'h2B2B});
    tick();
    check("same_final_we", rfWriteEn, 1);
    check("same_final_data", rfWriteData, 16'h2B2B);
    check("same_drained", pendingCount, 0);
    tick();

    // fill: A busy while B offers five entries into a 4-deep FIFO
    cnt_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i < 6, 1'b0, 3'd7, 16'(16'h7000 + i), nb < 5, 3'(nb), 16'(16'h00B0 + nb));
      exp_ready = !(i >= 4 && i <= 6);
      #1;
      check($sformatf("fill_ready_c%0d", i), secReady, exp_ready);
      check($sformatf("fill_stall_c%0d", i), wbStall, 0);
      if (secValid && exp_ready) nb++;
      if (i < 6) exp_q.push_back({3'd7, 16'(16'h7000 + i)});
      if (i == 5) begin
        for (int j = 0; j < 5; j++) exp_q.push_back({3'(j), 16'(16'h00B0 + j)});
      end
      tick();
      check($sformatf("fill_count_c%0d", i), pendingCount, cnt_exp[i]);
    end
    idle();
    tick();

    // asynchronous reset with two entries queued: none of them may be written
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 3'd7, 16'(16'h7700 + i), 1'b1, 3'(i), 16'(16'h00E0 + i));
      exp_q.push_back({3'd7, 16'(16'h7700 + i)});
      tick();
    end
    idle();
    check("rst_pre_count", pendingCount, 2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_we", rfWriteEn, 0);
    check("rst_async_waddr", rfWriteAddr, 0);
    check("rst_async_wdata", rfWriteData, 0);
    check("rst_async_port", outputPort, 0);
    check("rst_async_strobe", outStrobe, 0);
    check("rst_async_count", pendingCount, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rst_post_count", pendingCount, 0);
    check("rst_post_we", rfWriteEn, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
